// File: rtl/mem_mock_resp.sv
// Memory-responder model: single-word reads and byte-enabled writes over req/ack.
// ack arrives 1+LATENCY(+STALL_CYC on random stalls) cycles after req; req is held until ack.
module mem_mock_resp #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 16,
  parameter int                 DEPTH     = 1024,
  parameter int                 LATENCY   = 1,
  parameter int                 STALL_CYC = 3,
  parameter logic [15:0]        SEED      = 16'hACE1,
  parameter logic [DATA_W-1:0]  PATTERN   = DATA_W'('h5A5A)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  stall_en,
  output logic                  ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int              BE_W    = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [4:0]      LAT_L   = 5'(LATENCY);
  localparam logic [4:0]      STALL_L = 5'(STALL_CYC);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state, state_nxt;
  logic [4:0]          cnt;
  logic [4:0]          wait_cyc;
  logic [15:0]         lfsr;

  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [BE_W-1:0]     cap_be;

  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BE_W-1:0]     cur_be;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    vld;

  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   pat;
  logic [DATA_W-1:0]   base;
  logic [DATA_W-1:0]   merged;
  logic                enter_ack;

  // A zero-wait transaction accesses memory on the same edge it is sampled,
  // so the live inputs are used in IDLE and the captured copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_be    = be;
    end else begin
      cur_we    = cap_we;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      cur_be    = cap_be;
    end
  end

  always_comb begin
    wait_cyc = LAT_L + ((stall_en && lfsr[0]) ? STALL_L : 5'd0);
    in_range = {1'b0, cur_addr} < DEPTH_L;
    idx      = cur_addr[IDX_W-1:0];
    pat      = DATA_W'(cur_addr) ^ PATTERN;
    base     = (in_range && vld[idx]) ? mem[idx] : pat;
    merged   = base;
    for (int i = 0; i < BE_W; i++) begin
      if (cur_be[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (wait_cyc == 5'd0) ? ACK : WAIT;
      WAIT:    if (cnt <= 5'd1) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_ack = (state_nxt == ACK);

  // Outputs decoded from state
  always_comb begin
    ack  = (state == ACK);
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= SEED;
      vld       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == IDLE && req) begin
        cnt       <= wait_cyc;
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_be    <= be;
      end else if (state == WAIT) begin
        cnt <= cnt - 5'd1;
      end
      if (enter_ack) begin
        err   <= !in_range;
        rdata <= (!cur_we && in_range) ? base : '0;
        if (cur_we && in_range) vld[idx] <= 1'b1;
        if (cur_we) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  // Storage itself is never reset; the valid bits decide what it means.
  always_ff @(posedge clk) begin
    if (reset_n && enter_ack && cur_we && in_range) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_mem_mock_resp.sv
// Bench for mem_mock_resp: a LATENCY=0 instance and a LATENCY=4 instance, scoreboard-checked.
module tb_mem_mock_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        stall_en;
    logic        rst_n;
  } in_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        busy;
    logic [15:0] rdata;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
  } out_t;

  typedef struct {
    int          d;
    int          issue;
    int          lat;
    logic        we;
    logic [15:0] rd;
    logic        err;
    logic [15:0] rdc;
    logic [15:0] wrc;
  } item_t;

  in_t   in_s [2];
  out_t  o0, o1;
  item_t sbq [$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat_base [2] = '{0, 4};
  int          nrd [2] = '{0, 0};
  int          nwr [2] = '{0, 0};
  bit          held [2] = '{1'b0, 1'b0};
  int          busy_run [2] = '{0, 0};
  logic [15:0] lfsr_m [2];

  mem_mock_resp #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(0), .STALL_CYC(3),
                  .SEED(16'hACE1), .PATTERN(16'h5A5A)) u_lat0 (
    .clk(clk), .reset_n(in_s[0].rst_n), .req(in_s[0].req), .we(in_s[0].we),
    .addr(in_s[0].addr), .wdata(in_s[0].wdata), .be(in_s[0].be), .stall_en(in_s[0].stall_en),
    .ack(o0.ack), .rdata(o0.rdata), .err(o0.err), .busy(o0.busy),
    .rd_count(o0.rd_count), .wr_count(o0.wr_count));

  mem_mock_resp #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(4), .STALL_CYC(3),
                  .SEED(16'hACE1), .PATTERN(16'h5A5A)) u_lat4 (
    .clk(clk), .reset_n(in_s[1].rst_n), .req(in_s[1].req), .we(in_s[1].we),
    .addr(in_s[1].addr), .wdata(in_s[1].wdata), .be(in_s[1].be), .stall_en(in_s[1].stall_en),
    .ack(o1.ack), .rdata(o1.rdata), .err(o1.err), .busy(o1.busy),
    .rd_count(o1.rd_count), .wr_count(o1.wr_count));

  function automatic out_t outs(input int d);
    return (d != 0) ? o1 : o0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference stall source: 16-bit Fibonacci LFSR, taps 16,14,13,11
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!in_s[d].rst_n) lfsr_m[d] <= 16'hACE1;
      else lfsr_m[d] <= {lfsr_m[d][14:0],
                         lfsr_m[d][15] ^ lfsr_m[d][13] ^ lfsr_m[d][12] ^ lfsr_m[d][10]};
    end
  end

  // Monitor: pops the scoreboard whenever either instance pulses ack
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (outs(d).busy) busy_run[d]++;
      else busy_run[d] = 0;
      if (outs(d).ack) begin
        chk("sb_has_item", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          item_t it;
          it = sbq.pop_front();
          chk("sb_dut", d, it.d);
          chk("ack_latency", cyc - it.issue, it.lat);
          chk("busy_cycles", busy_run[d], it.lat);
          chk("err", outs(d).err, it.err);
          if (!it.we || it.err) chk("rdata", outs(d).rdata, it.rd);
          chk("rd_count", outs(d).rd_count, it.rdc);
          chk("wr_count", outs(d).wr_count, it.wrc);
        end
      end
    end
  end

  // Issue one transaction from a negedge; returns at a negedge once ack is seen.
  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] b, input logic [15:0] erd, input logic eerr,
                     input bit hold = 1'b0, input bit perturb = 1'b0);
    item_t it;
    bit    got;
    in_s[d].req   = 1'b1;
    in_s[d].we    = w;
    in_s[d].addr  = a;
    in_s[d].wdata = wd;
    in_s[d].be    = b;
    it.d     = d;
    it.issue = held[d] ? cyc + 1 : cyc;
    it.lat   = 1 + lat_base[d] + ((in_s[d].stall_en && lfsr_m[d][0]) ? 3 : 0);
    it.we    = w;
    it.rd    = erd;
    it.err   = eerr;
    if (w) nwr[d]++;
    else nrd[d]++;
    it.rdc = 16'(nrd[d]);
    it.wrc = 16'(nwr[d]);
    sbq.push_back(it);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (perturb && i == 1) begin
        in_s[d].req   = 1'b0;
        in_s[d].we    = ~w;
        in_s[d].addr  = ~a;
        in_s[d].wdata = ~wd;
      end
      got = outs(d).ack;
    end
    chk("ack_within_budget", got, 1);
    if (!got) void'(sbq.pop_back());
    held[d] = hold;
    if (!hold) begin
      in_s[d].req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input int d);
    chk("rst_ack", outs(d).ack, 0);
    chk("rst_busy", outs(d).busy, 0);
    chk("rst_err", outs(d).err, 0);
    chk("rst_rdata", outs(d).rdata, 0);
    chk("rst_rd_count", outs(d).rd_count, 0);
    chk("rst_wr_count", outs(d).wr_count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    in_s[0] = '0;
    in_s[1] = '0;
    repeat (3) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    in_s[0].rst_n = 1'b1;
    in_s[1].rst_n = 1'b1;
    @(negedge clk);

    // LATENCY=0 instance: basic, pattern, partial, boundary and out-of-range traffic
    txn(0, 1, 16'd3,    16'h1234, 2'b11, 16'h0000, 0);
    txn(0, 0, 16'd3,    16'h0000, 2'b00, 16'h1234, 0);
    txn(0, 0, 16'd7,    16'h0000, 2'b00, 16'h5A5D, 0);
    txn(0, 1, 16'd0,    16'hFFEE, 2'b01, 16'h0000, 0);
    txn(0, 0, 16'd0,    16'h0000, 2'b00, 16'h5AEE, 0);
    txn(0, 1, 16'd3,    16'hAB00, 2'b10, 16'h0000, 0);
    txn(0, 0, 16'd3,    16'h0000, 2'b00, 16'hAB34, 0);
    txn(0, 0, 16'd1024, 16'h0000, 2'b00, 16'h0000, 1);
    txn(0, 0, 16'd3,    16'h0000, 2'b00, 16'hAB34, 0);
    txn(0, 0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1);
    txn(0, 1, 16'd1024, 16'hFFFF, 2'b11, 16'h0000, 1);
    txn(0, 0, 16'd0,    16'h0000, 2'b00, 16'h5AEE, 0);
    txn(0, 0, 16'd1023, 16'h0000, 2'b00, 16'h59A5, 0);
    txn(0, 1, 16'd1023, 16'h7700, 2'b10, 16'h0000, 0);
    txn(0, 0, 16'd1023, 16'h0000, 2'b00, 16'h77A5, 0);
    txn(0, 1, 16'd10,   16'hA1B2, 2'b11, 16'h0000, 0, 1'b1);
    txn(0, 0, 16'd10,   16'h0000, 2'b00, 16'hA1B2, 0, 1'b1);
    txn(0, 0, 16'd7,    16'h0000, 2'b00, 16'h5A5D, 0);

    // LATENCY=4 instance: fixed latency, ignored mid-transaction changes, stalls
    txn(1, 1, 16'd5, 16'h0BAD, 2'b11, 16'h0000, 0);
    txn(1, 0, 16'd5, 16'h0000, 2'b00, 16'h0BAD, 0);
    txn(1, 0, 16'd5, 16'h0000, 2'b00, 16'h0BAD, 0, 1'b0, 1'b1);
    in_s[1].stall_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      txn(1, 0, 16'd5, 16'h0000, 2'b00, 16'h0BAD, 0);
      repeat (n % 3) @(negedge clk);
    end
    in_s[1].stall_en = 1'b0;

    // Reset while the transaction sits in WAIT
    in_s[1].req  = 1'b1;
    in_s[1].we   = 1'b0;
    in_s[1].addr = 16'd5;
    repeat (2) @(negedge clk);
    chk("busy_in_wait", outs(1).busy, 1);
    in_s[1].rst_n = 1'b0;
    in_s[1].req   = 1'b0;
    @(negedge clk);
    chk_reset_state(1);
    in_s[1].rst_n = 1'b1;
    nrd[1]  = 0;
    nwr[1]  = 0;
    held[1] = 1'b0;

    // First request right after reset sees lfsr=SEED (bit0=1), so it stalls
    in_s[1].stall_en = 1'b1;
    txn(1, 0, 16'd5, 16'h0000, 2'b00, 16'h5A5F, 0);
    txn(1, 0, 16'd9, 16'h0000, 2'b00, 16'h5A53, 0);
    in_s[1].stall_en = 1'b0;
    txn(1, 0, 16'd1024, 16'h0000, 2'b00, 16'h0000, 1);

    repeat (8) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_mock_resp.md
# mem_mock_resp

Parametrised memory-responder model for the matrix-multiplier benches; it replaces the fixed one-line ack toggler on the result bus with a configurable slave. It serves single-word reads and byte-enabled writes over a req/ack handshake, with programmable response latency and pseudo-random stall insertion. Per-word backing storage lets the bench read back the results the DUT wrote. Transaction counters and an out-of-range error flag support scoreboarding.

## Interface
- DATA_W, 16, data width; multiple of 8
- ADDR_W, 16, address width
- DEPTH, 1024, words of storage; DEPTH <= 2**ADDR_W
- LATENCY, 1, wait cycles before ack (0..15)
- STALL_CYC, 3, extra wait cycles when a stall is drawn (0..15)
- SEED, 16'hACE1, LFSR reset value; nonzero
- PATTERN, 'h5A5A (DATA_W bits), XOR mask for unwritten-word read data

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  1  request; held with we/addr/wdata/be until ack seen
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  DATA_W/8  byte enables, writes only
- stall_en  in  1  enables random stall insertion
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while ack=1
- err  out  1  out-of-range flag, valid while ack=1
- busy  out  1  transaction in progress (state != IDLE)
- rd_count  out  16  completed reads, saturating
- wr_count  out  16  completed writes, saturating

## Operation
- States: IDLE, WAIT, ACK.
- IDLE, req=1: capture we/addr/wdata/be and set wait = LATENCY + (stall_en && lfsr[0] ? STALL_CYC : 0). Go to ACK if wait==0, else WAIT.
- WAIT: decrement wait each cycle; on the cycle wait reaches 1, go to ACK.
- ACK: ack=1 for exactly one cycle, then IDLE unconditionally.
- If req is still 1 in the following IDLE cycle, it starts a new transaction; back-to-back transfers are supported.
- Memory access is performed on the edge entering ACK; rdata and err are registered on that same edge.
- Read, in range: a written word returns its stored value. An unwritten word returns zero-extended addr XOR PATTERN.
- Write, in range: merge wdata bytes where be=1. The base for the merge is the stored word, or the pattern value if the word is unwritten. Set the word's valid bit.
- addr >= DEPTH: no storage change. rdata=0, err=1. Counters still increment.
- Counters increment on entering ACK and saturate at 16'hFFFF.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state.
- Captured fields are not re-sampled during WAIT. Input changes mid-transaction are ignored.

## Timing
- Reset (reset_n=0 at a rising edge) applies on that edge, including mid-transaction. Resulting values:
  - state=IDLE; ack, err, busy = 0
  - rdata = 0
  - rd_count, wr_count = 0
  - all valid bits cleared
  - lfsr = SEED
- Storage contents are not reset; only valid bits are cleared.
- req sampled 1 at edge k in IDLE gives ack=1 during cycle k+1+wait. Minimum is 2 cycles per transaction with LATENCY=0.
- busy=1 from cycle k+1 through the ack cycle inclusive.
- A req that falls during WAIT does not cancel the transaction; ack still pulses.

## Test plan
- LATENCY=0: write addr 3, data 16'h1234, be=2'b11; then read addr 3 → ack 1 cycle after req; rdata=16'h1234, err=0; wr_count=1, rd_count=1.
- Read unwritten addr 7 with PATTERN=16'h5A5A → rdata=16'h5A5D.
- Partial write: be=2'b01, wdata=16'hFFEE to unwritten addr 0 → read gives 16'h5AEE.
- LATENCY=4, stall_en=0: ack exactly 5 cycles after req, busy high 5 cycles. With stall_en=1, each ack latency is either 5 or 8 cycles, and the sequence matches a reference LFSR from SEED.
- Read at addr=DEPTH → ack, err=1, rdata=0, rd_count incremented. A subsequent in-range read shows err=0.
- Reset asserted during WAIT: next cycle ack=0, busy=0, counters 0. A previously written word then reads back its pattern value.
